// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control path: FSM states, opcodes,
// and the mux/ALU select codes also consumed by imm_gen and the datapath.
package rv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_ILLEGAL  = 4'd11
  } state_e;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_J = 2'b11
  } imm_src_e;

  typedef enum logic [1:0] {
    SRCA_PC    = 2'b00,
    SRCA_OLDPC = 2'b01,
    SRCA_RS1   = 2'b10
  } src_a_e;

  typedef enum logic [1:0] {
    SRCB_RS2  = 2'b00,
    SRCB_IMM  = 2'b01,
    SRCB_FOUR = 2'b10
  } src_b_e;

  typedef enum logic [1:0] {
    RES_ALUOUT = 2'b00,
    RES_MEM    = 2'b01,
    RES_ALU    = 2'b10
  } result_src_e;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_ctrl_e;

endpackage

// File: rtl/mc_control_fsm_alu_decoder.sv
// Maps the FSM's coarse alu_op plus instruction function bits to an ALU opcode.
module alu_decoder
  import rv_ctrl_pkg::*;
(
  input  alu_op_e     alu_op_i,
  input  logic [2:0]  funct3_i,
  input  logic        funct7b5_i,
  input  logic        op5_i,
  output logic [2:0]  alu_control_o
);

  always_comb begin
    alu_control_o = ALU_ADD;
    case (alu_op_i)
      ALUOP_SUB: alu_control_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3_i)
          // funct7b5 only selects sub for R-type; for addi it is immediate bits
          3'b000:  alu_control_o = (op5_i & funct7b5_i) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control_o = ALU_SLT;
          3'b110:  alu_control_o = ALU_OR;
          3'b111:  alu_control_o = ALU_AND;
          default: alu_control_o = ALU_ADD;
        endcase
      end
      default: alu_control_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle RV32I control FSM with a watchdog bounding every memory wait.
module mc_control_fsm
  import rv_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic [1:0] imm_src,
  output logic [2:0] alu_control,
  output logic       illegal_instr,
  output logic       bus_err
);

  state_e     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       mem_state, timeout;
  alu_op_e    alu_op;
  logic [2:0] alu_ctrl_raw;

  assign mem_state = (state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE);
  assign timeout   = mem_state && !mem_ready && (wait_cnt_q == 8'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_FETCH;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_BEQ:            state_d = S_BEQ;
          OP_JAL:            state_d = S_JAL;
          default:           state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR:   state_d = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
      S_EXECR, S_EXECI, S_JAL: state_d = S_ALUWB;
      default:    state_d = S_FETCH;
    endcase
    // Watchdog abandons the access and restarts from FETCH; FETCH->FETCH still clears the count
    if (timeout) state_d = S_FETCH;
    wait_cnt_d = (mem_state && !mem_ready && !timeout) ? wait_cnt_q + 8'd1 : '0;
  end

  alu_decoder u_alu_decoder (
    .alu_op_i      (alu_op),
    .funct3_i      (funct3),
    .funct7b5_i    (funct7b5),
    .op5_i         (opcode[5]),
    .alu_control_o (alu_ctrl_raw)
  );

  always_comb begin
    logic pc_update, branch;
    pc_update     = 1'b0;
    branch        = 1'b0;
    alu_op        = ALUOP_ADD;
    mem_req       = 1'b0;
    mem_write     = 1'b0;
    adr_src       = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = SRCA_PC;
    alu_src_b     = SRCB_RS2;
    result_src    = RES_ALUOUT;
    imm_src       = IMM_I;
    illegal_instr = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU;
        ir_write   = mem_ready;
        pc_update  = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        imm_src   = IMM_B;
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        imm_src   = (opcode == OP_STORE) ? IMM_S : IMM_I;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
      end
      S_MEMWB: begin
        result_src = RES_MEM;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = 1'b1;
      end
      S_EXECR: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALUOP_FUNCT;
      end
      S_EXECI: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: reg_write = 1'b1;
      S_BEQ: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALUOP_SUB;
        branch    = 1'b1;
      end
      S_JAL: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        pc_update = 1'b1;
        imm_src   = IMM_J;
      end
      S_ILLEGAL: illegal_instr = 1'b1;
      default: ;
    endcase
    pc_write    = pc_update | (branch & zero);
    bus_err     = timeout;
    alu_control = alu_ctrl_raw;
    if (rst) begin
      mem_req       = 1'b0;
      mem_write     = 1'b0;
      adr_src       = 1'b0;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = '0;
      alu_src_b     = '0;
      result_src    = '0;
      imm_src       = '0;
      alu_control   = '0;
      illegal_instr = 1'b0;
      bus_err       = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench: expands each instruction into its expected per-cycle output trace.
module tb_mc_control_fsm;

  localparam int unsigned TO = 16;

  typedef struct packed {
    logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
    logic [1:0] src_a, src_b, result_src, imm_src;
    logic [2:0] alu_control;
    logic       illegal, bus_err;
  } out_t;

  typedef struct {
    logic       rst, mem_ready, zero;
    logic [6:0] opc;
    logic [2:0] f3;
    logic       f7;
    out_t       exp;
    int         tag;
    string      name;
  } stim_t;

  logic clk = 1'b0;
  logic rst, zero, mem_ready, funct7b5;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, illegal_instr, bus_err;
  logic [1:0] alu_src_a, alu_src_b, result_src, imm_src;
  logic [2:0] alu_control;

  always #5 clk = ~clk;

  mc_control_fsm #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write),
    .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .result_src(result_src),
    .imm_src(imm_src), .alu_control(alu_control), .illegal_instr(illegal_instr),
    .bus_err(bus_err)
  );

  stim_t      stim_q[$];
  logic [6:0] cur_opc;
  logic [2:0] cur_f3;
  logic       cur_f7, cur_zero;
  int         checks = 0;
  int         failures = 0;
  int         idx = 0;
  bit         run = 0;

  function automatic out_t o_fetch(logic rdy, logic berr);
    out_t e = '0;
    e.mem_req = 1; e.src_b = 2'b10; e.result_src = 2'b10;
    e.ir_write = rdy; e.pc_write = rdy; e.bus_err = berr;
    return e;
  endfunction
  function automatic out_t o_decode();
    out_t e = '0;
    e.src_a = 2'b01; e.src_b = 2'b01; e.imm_src = 2'b10;
    return e;
  endfunction
  function automatic out_t o_memadr(logic store);
    out_t e = '0;
    e.src_a = 2'b10; e.src_b = 2'b01; e.imm_src = store ? 2'b01 : 2'b00;
    return e;
  endfunction
  function automatic out_t o_mem(logic wr, logic berr);
    out_t e = '0;
    e.mem_req = 1; e.adr_src = 1; e.mem_write = wr; e.bus_err = berr;
    return e;
  endfunction
  function automatic out_t o_wb(logic from_mem);
    out_t e = '0;
    e.reg_write = 1; e.result_src = from_mem ? 2'b01 : 2'b00;
    return e;
  endfunction
  function automatic out_t o_exec(logic use_imm, logic [2:0] alu);
    out_t e = '0;
    e.src_a = 2'b10; e.src_b = use_imm ? 2'b01 : 2'b00; e.alu_control = alu;
    return e;
  endfunction
  function automatic out_t o_beq(logic z);
    out_t e = '0;
    e.src_a = 2'b10; e.alu_control = 3'b001; e.pc_write = z;
    return e;
  endfunction
  function automatic out_t o_jal();
    out_t e = '0;
    e.src_a = 2'b01; e.src_b = 2'b10; e.pc_write = 1; e.imm_src = 2'b11;
    return e;
  endfunction
  function automatic out_t o_ill();
    out_t e = '0;
    e.illegal = 1;
    return e;
  endfunction

  task automatic push(input string nm, input logic r, input logic rdy, input out_t e);
    stim_t s;
    s.rst = r; s.mem_ready = rdy; s.zero = cur_zero;
    s.opc = cur_opc; s.f3 = cur_f3; s.f7 = cur_f7;
    s.exp = e; s.tag = 0; s.name = nm;
    stim_q.push_back(s);
  endtask

  // kind: 0 fetch, 1 load, 2 store; a stall of TO or more cycles ends in bus_err
  task automatic mem_wait(input int kind, input int stall, output bit aborted);
    aborted = 0;
    for (int k = 0; k < stall; k++) begin
      if (k == int'(TO) - 1) begin
        push("timeout", 0, 0, (kind == 0) ? o_fetch(0, 1) : o_mem(kind == 2, 1));
        aborted = 1;
        return;
      end
      push("stall", 0, 0, (kind == 0) ? o_fetch(0, 0) : o_mem(kind == 2, 0));
    end
    push("ready", 0, 1, (kind == 0) ? o_fetch(1, 0) : o_mem(kind == 2, 0));
  endtask

  task automatic instr(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                       input logic z, input logic [2:0] alu, input int fst, input int mst);
    bit ab;
    cur_opc = opc; cur_f3 = f3; cur_f7 = f7; cur_zero = z;
    mem_wait(0, fst, ab);
    if (ab) return;
    push("decode", 0, 1, o_decode());
    case (opc)
      7'b0000011: begin
        push("memadr", 0, 1, o_memadr(0));
        mem_wait(1, mst, ab);
        if (!ab) push("memwb", 0, 1, o_wb(1));
      end
      7'b0100011: begin
        push("memadr", 0, 1, o_memadr(1));
        mem_wait(2, mst, ab);
      end
      7'b0110011: begin
        push("execr", 0, 1, o_exec(0, alu));
        push("aluwb", 0, 1, o_wb(0));
      end
      7'b0010011: begin
        push("execi", 0, 1, o_exec(1, alu));
        push("aluwb", 0, 1, o_wb(0));
      end
      7'b1100011: push("beq", 0, 1, o_beq(z));
      7'b1101111: begin
        push("jal", 0, 1, o_jal());
        push("aluwb", 0, 1, o_wb(0));
      end
      default: push("illegal", 0, 1, o_ill());
    endcase
  endtask

  task automatic lit(input string nm, input logic [3:0] act, input logic [3:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%b required=%b", nm, idx, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (run) begin
      out_t act;
      act = '{mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, alu_src_a,
              alu_src_b, result_src, imm_src, alu_control, illegal_instr, bus_err};
      checks++;
      if (act !== stim_q[idx].exp) begin
        failures++;
        $display("FAIL %s cyc=%0d actual=%h required=%h", stim_q[idx].name, idx,
                 act, stim_q[idx].exp);
      end
      case (stim_q[idx].tag)
        1: lit("post_reset_fetch", {2'b00, mem_req, ir_write}, 4'b0011);
        2: lit("add_alu_control", {1'b0, alu_control}, 4'b0000);
        3: lit("beq_taken_pc_write", {3'b000, pc_write}, 4'b0001);
        4: lit("beq_not_taken_pc_write", {3'b000, pc_write}, 4'b0000);
        5: lit("illegal_pulse", {1'b0, illegal_instr, reg_write, mem_write}, 4'b0100);
        6: lit("fetch_timeout", {1'b0, bus_err, ir_write, pc_write}, 4'b0100);
        7: lit("rst_mid_store", {2'b00, mem_req, mem_write}, 4'b0000);
        default: ;
      endcase
    end
  end

  initial begin
    int base;
    bit ab;
    rst = 1; mem_ready = 0; zero = 0; opcode = '0; funct3 = '0; funct7b5 = 0;
    cur_opc = '0; cur_f3 = '0; cur_f7 = 0; cur_zero = 0;

    push("reset0", 1, 1, '0);
    push("reset1", 1, 1, '0);
    base = stim_q.size();
    instr(7'b0110011, 3'b000, 0, 0, 3'b000, 0, 0);        // add
    stim_q[base].tag = 1;
    stim_q[base + 2].tag = 2;
    instr(7'b0110011, 3'b000, 1, 0, 3'b001, 0, 0);        // sub
    instr(7'b0110011, 3'b010, 0, 0, 3'b101, 0, 0);        // slt
    instr(7'b0110011, 3'b110, 0, 0, 3'b011, 0, 0);        // or
    instr(7'b0110011, 3'b111, 0, 0, 3'b010, 0, 0);        // and
    instr(7'b0110011, 3'b100, 0, 0, 3'b000, 0, 0);        // xor: unsupported funct3 -> add
    instr(7'b0010011, 3'b000, 1, 0, 3'b000, 0, 0);        // addi with imm bit30 set
    instr(7'b0010011, 3'b110, 0, 0, 3'b011, 0, 0);        // ori
    instr(7'b0010011, 3'b010, 0, 0, 3'b101, 0, 0);        // slti
    instr(7'b0000011, 3'b010, 0, 0, 3'b000, 1, 2);        // lw, stalls
    instr(7'b0100011, 3'b010, 0, 0, 3'b000, 0, 0);        // sw
    instr(7'b0100011, 3'b010, 0, 0, 3'b000, 0, TO - 1);   // sw, longest legal wait
    instr(7'b1100011, 3'b000, 0, 1, 3'b001, 0, 0);        // beq taken
    stim_q[stim_q.size() - 1].tag = 3;
    instr(7'b1100011, 3'b000, 0, 0, 3'b001, 0, 0);        // beq not taken
    stim_q[stim_q.size() - 1].tag = 4;
    instr(7'b1101111, 3'b000, 0, 0, 3'b000, 0, 0);        // jal
    instr(7'b0110111, 3'b000, 0, 0, 3'b000, 0, 0);        // lui -> illegal
    stim_q[stim_q.size() - 1].tag = 5;
    instr(7'b0110011, 3'b000, 0, 0, 3'b000, TO, 0);       // fetch timeout
    stim_q[stim_q.size() - 1].tag = 6;
    instr(7'b0110011, 3'b111, 0, 0, 3'b010, 0, 0);        // and, after recovery
    instr(7'b0000011, 3'b010, 0, 0, 3'b000, 0, TO + 3);   // lw, read timeout

    cur_opc = 7'b0100011; cur_f3 = 3'b010; cur_f7 = 0; cur_zero = 0;
    mem_wait(0, 0, ab);
    push("decode", 0, 1, o_decode());
    push("memadr", 0, 1, o_memadr(1));
    push("stall", 0, 0, o_mem(1, 0));
    push("stall", 0, 0, o_mem(1, 0));
    push("rst_mid", 1, 1, '0);
    stim_q[stim_q.size() - 1].tag = 7;
    instr(7'b0110011, 3'b000, 1, 0, 3'b001, 0, 0);        // sub after reset

    for (int i = 0; i < stim_q.size(); i++) begin
      @(posedge clk);
      #1;
      rst = stim_q[i].rst; mem_ready = stim_q[i].mem_ready; zero = stim_q[i].zero;
      opcode = stim_q[i].opc; funct3 = stim_q[i].f3; funct7b5 = stim_q[i].f7;
      idx = i;
      run = 1;
    end
    @(posedge clk);
    #1;
    run = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
